// File: rtl/exec_ctrl.sv
// exec_ctrl: run / single-step / breakpoint execution controller for a small core.
// Synchronizes the run switch and step button, debounces the button, and drives a
// registered one-instruction clock-enable (cpu_en) from a four-state FSM.
// Optional feature macro: EXEC_CTRL_CYCLE_CNT_EN enables the saturating
// executed-instruction counter on cyc_cnt; without it cyc_cnt is tied to zero.
module exec_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV   = 50000000,
    parameter int DEB   = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic [WIDTH-1:0] pc,
    input  logic             bp_en,
    input  logic [WIDTH-1:0] bp_addr,
    output logic             cpu_en,
    output logic             halted,
    output logic             bp_hit,
    output logic [1:0]       state,
    output logic [15:0]      cyc_cnt
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW = $clog2(DEB + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB - 1);

    typedef enum logic [1:0] {
        S_HALT  = 2'b00,
        S_RUN   = 2'b01,
        S_STEP  = 2'b10,
        S_BREAK = 2'b11
    } state_t;

    state_t          cur_state;
    state_t          nxt_state;
    logic            run_meta;
    logic            run_sync;
    logic            step_meta;
    logic            step_sync;
    logic            step_stable;
    logic [DW-1:0]   deb_cnt;
    logic            step_evt;
    logic [PW-1:0]   presc;
    logic            skip_bp;
    logic            tick;
    logic            bp_match;
    logic            cpu_en_nxt;
    logic            skip_set;
    logic            skip_clr;

    // Two-flop synchronizers bring both asynchronous operator inputs into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_meta  <= 1'b0;
            run_sync  <= 1'b0;
            step_meta <= 1'b0;
            step_sync <= 1'b0;
        end else begin
            run_meta  <= run_sw;
            run_sync  <= run_meta;
            step_meta <= step_btn;
            step_sync <= step_meta;
        end
    end

    // Debouncer: accept a new button level after DEB consecutive differing cycles; a rise fires step_evt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_stable <= 1'b0;
            deb_cnt     <= '0;
            step_evt    <= 1'b0;
        end else begin
            step_evt <= 1'b0;
            if (step_sync != step_stable) begin
                if (deb_cnt == DEB_LAST) begin
                    step_stable <= step_sync;
                    deb_cnt     <= '0;
                    step_evt    <= step_sync;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    assign tick     = (presc == PRESC_LAST);
    assign bp_match = bp_en && (pc == bp_addr) && !skip_bp;

    // Next-state and next-pulse decode; a STEP state always carries exactly one cpu_en cycle.
    always_comb begin
        nxt_state  = cur_state;
        cpu_en_nxt = 1'b0;
        skip_set   = 1'b0;
        skip_clr   = 1'b0;
        case (cur_state)
            S_HALT: begin
                if (step_evt) begin
                    nxt_state = S_STEP;
                end else if (run_sync) begin
                    nxt_state = S_RUN;
                    skip_set  = 1'b1;
                end
            end
            S_STEP: begin
                nxt_state = S_HALT;
            end
            S_RUN: begin
                if (!run_sync) begin
                    nxt_state = S_HALT;
                end else if (tick) begin
                    if (bp_match) begin
                        nxt_state = S_BREAK;
                    end else begin
                        cpu_en_nxt = 1'b1;
                        skip_clr   = 1'b1;
                    end
                end
            end
            S_BREAK: begin
                if (step_evt) begin
                    nxt_state = S_STEP;
                end else if (!run_sync) begin
                    nxt_state = S_HALT;
                end
            end
            default: begin
                nxt_state = S_HALT;
            end
        endcase
        if (nxt_state == S_STEP) begin
            cpu_en_nxt = 1'b1;
        end
    end

    // State register, registered clock-enable, breakpoint-skip flag and RUN-mode prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_HALT;
            cpu_en    <= 1'b0;
            skip_bp   <= 1'b0;
            presc     <= '0;
        end else begin
            cur_state <= nxt_state;
            cpu_en    <= cpu_en_nxt;
            if (skip_set) begin
                skip_bp <= 1'b1;
            end else if (skip_clr) begin
                skip_bp <= 1'b0;
            end
            if ((cur_state == S_RUN) && (nxt_state == S_RUN)) begin
                presc <= tick ? '0 : presc + 1'b1;
            end else begin
                presc <= '0;
            end
        end
    end

    assign halted = (cur_state == S_HALT) || (cur_state == S_BREAK);
    assign bp_hit = (cur_state == S_BREAK);
    assign state  = cur_state;

`ifdef EXEC_CTRL_CYCLE_CNT_EN
    logic [15:0] cnt_q;

    // Saturating count of cpu_en high cycles, i.e. instructions executed since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cpu_en && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cyc_cnt = cnt_q;
`else
    assign cyc_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: directed bench for exec_ctrl (DIV=4, DEB=3, WIDTH=8) plus a DIV=1
// instance for the instruction-counter saturation case. Expected cpu_en pulses
// (cycle and pc) are queued when stimulus is applied and popped as pulses appear.
module tb_exec_ctrl;

    typedef struct {
        int         cycle;
        logic [7:0] pcv;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        run_sw;
    logic        step_btn;
    logic [7:0]  pc;
    logic        bp_en;
    logic [7:0]  bp_addr;
    logic        cpu_en;
    logic        halted;
    logic        bp_hit;
    logic [1:0]  state;
    logic [15:0] cyc_cnt;

    logic        rst2_n;
    logic        run_sw2;
    logic        cpu_en2;
    logic        halted2;
    logic        bp_hit2;
    logic [1:0]  state2;
    logic [15:0] cyc_cnt2;

    logic [7:0]  pc_off;
    logic [7:0]  pc_adj;
    logic        prev_en;
    int          cyc;
    int          tests;
    int          fails;
    int          pulses;
    int          cnt2;
    exp_t        sb[$];

    assign pc = pc_off + pc_adj;

    exec_ctrl #(.WIDTH(8), .DIV(4), .DEB(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run_sw   (run_sw),
        .step_btn (step_btn),
        .pc       (pc),
        .bp_en    (bp_en),
        .bp_addr  (bp_addr),
        .cpu_en   (cpu_en),
        .halted   (halted),
        .bp_hit   (bp_hit),
        .state    (state),
        .cyc_cnt  (cyc_cnt)
    );

    exec_ctrl #(.WIDTH(8), .DIV(1), .DEB(3)) dut2 (
        .clk      (clk),
        .rst_n    (rst2_n),
        .run_sw   (run_sw2),
        .step_btn (1'b0),
        .pc       (8'h00),
        .bp_en    (1'b0),
        .bp_addr  (8'h00),
        .cpu_en   (cpu_en2),
        .halted   (halted2),
        .bp_hit   (bp_hit2),
        .state    (state2),
        .cyc_cnt  (cyc_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic run, input logic step);
        run_sw   = run;
        step_btn = step;
    endtask

    task automatic pushPulse(input int cycle, input logic [7:0] pcv);
        exp_t e;
        e.cycle = cycle;
        e.pcv   = pcv;
        sb.push_back(e);
    endtask

    function automatic logic [15:0] expCnt(input int n);
`ifdef EXEC_CTRL_CYCLE_CNT_EN
        return (n > 65535) ? 16'hFFFF : 16'(n);
`else
        return (n < 0) ? 16'hFFFF : 16'h0000;
`endif
    endfunction

    // Advance to the next falling edge and score any cpu_en pulse against the queue.
    task automatic nextCycle();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (sb.size() != 0 && sb[0].cycle < cyc) begin
            checkOutput("pulse_missing", cyc, sb[0].cycle);
            void'(sb.pop_front());
        end
        if (rst_n && cpu_en) begin
            checkOutput("pulse_expected", (sb.size() != 0), 1);
            checkOutput("no_back_to_back", prev_en, 0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput("pulse_cycle", cyc, e.cycle);
                checkOutput("pulse_pc", pc, e.pcv);
                pulses++;
            end
            pc_off = pc_off + 8'd1;
        end
        prev_en = cpu_en;
        if (rst2_n && cpu_en2) begin
            cnt2++;
        end
    endtask

    task automatic waitCycle(input int target);
        while (cyc < target) begin
            nextCycle();
        end
    endtask

    initial begin
        int t0;
        tests   = 0;
        fails   = 0;
        pulses  = 0;
        cnt2    = 0;
        cyc     = 0;
        prev_en = 1'b0;
        pc_off  = 8'h00;
        pc_adj  = 8'h00;
        rst_n   = 1'b0;
        rst2_n  = 1'b0;
        run_sw2 = 1'b1;
        bp_en   = 1'b0;
        bp_addr = 8'h00;
        applyStimulus(1'b0, 1'b0);

        nextCycle();
        nextCycle();
        checkOutput("reset_state", state, 2'b00);
        checkOutput("reset_cpu_en", cpu_en, 0);
        checkOutput("reset_halted", halted, 1);
        checkOutput("reset_bp_hit", bp_hit, 0);
        checkOutput("reset_cyc_cnt", cyc_cnt, 0);
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        nextCycle();
        checkOutput("halt_after_release", state, 2'b00);

        // Free run, then drop run_sw so its synchronized fall meets a tick.
        t0 = cyc;
        applyStimulus(1'b1, 1'b0);
        pushPulse(t0 + 7, pc);
        pushPulse(t0 + 11, pc + 8'd1);
        pushPulse(t0 + 15, pc + 8'd2);
        waitCycle(t0 + 2);
        checkOutput("run_sync_latency", state, 2'b00);
        waitCycle(t0 + 3);
        checkOutput("run_entered", state, 2'b01);
        checkOutput("run_halted", halted, 0);
        waitCycle(t0 + 16);
        applyStimulus(1'b0, 1'b0);
        waitCycle(t0 + 18);
        checkOutput("run_before_drop", state, 2'b01);
        waitCycle(t0 + 19);
        checkOutput("drop_on_tick_state", state, 2'b00);
        checkOutput("drop_on_tick_pulse", cpu_en, 0);
        waitCycle(t0 + 24);

        // One-cycle glitch must not step; a clean press steps once.
        t0 = cyc;
        applyStimulus(1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0);
        waitCycle(t0 + 12);
        checkOutput("glitch_state", state, 2'b00);
        t0 = cyc;
        applyStimulus(1'b0, 1'b1);
        pushPulse(t0 + 6, pc);
        waitCycle(t0 + 6);
        checkOutput("step_state", state, 2'b10);
        waitCycle(t0 + 7);
        checkOutput("step_return", state, 2'b00);
        waitCycle(t0 + 10);
        applyStimulus(1'b0, 1'b0);
        waitCycle(t0 + 20);

        // Breakpoint at 05 with pc starting at 03.
        pc_adj  = 8'h03 - pc_off;
        bp_en   = 1'b1;
        bp_addr = 8'h05;
        t0 = cyc;
        applyStimulus(1'b1, 1'b0);
        pushPulse(t0 + 7, 8'h03);
        pushPulse(t0 + 11, 8'h04);
        waitCycle(t0 + 14);
        checkOutput("bp_run", state, 2'b01);
        waitCycle(t0 + 15);
        checkOutput("bp_state", state, 2'b11);
        checkOutput("bp_hit", bp_hit, 1);
        checkOutput("bp_halted", halted, 1);
        waitCycle(t0 + 25);
        checkOutput("bp_hold", state, 2'b11);

        // Step out of BREAK, then resume running past the breakpoint.
        t0 = cyc;
        applyStimulus(1'b1, 1'b1);
        pushPulse(t0 + 6, 8'h05);
        pushPulse(t0 + 12, 8'h06);
        pushPulse(t0 + 16, 8'h07);
        pushPulse(t0 + 20, 8'h08);
        waitCycle(t0 + 6);
        checkOutput("bp_step_state", state, 2'b10);
        waitCycle(t0 + 7);
        checkOutput("bp_step_halt", state, 2'b00);
        waitCycle(t0 + 8);
        checkOutput("bp_resume", state, 2'b01);
        checkOutput("bp_resume_hit", bp_hit, 0);
        waitCycle(t0 + 9);
        applyStimulus(1'b1, 1'b0);
        waitCycle(t0 + 23);
        checkOutput("cyc_cnt_main", cyc_cnt, expCnt(pulses));
        checkOutput("run_still", state, 2'b01);

        // Reset while a pulse is on the output.
        @(posedge clk);
        #2;
        checkOutput("pulse_before_reset", cpu_en, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_run_cpu_en", cpu_en, 0);
        checkOutput("reset_mid_run_state", state, 2'b00);
        checkOutput("reset_mid_run_halted", halted, 1);
        checkOutput("reset_mid_run_cyc_cnt", cyc_cnt, 0);
        pulses = 0;
        nextCycle();
        applyStimulus(1'b0, 1'b0);
        nextCycle();
        rst_n = 1'b1;
        t0 = cyc;
        waitCycle(t0 + 6);
        checkOutput("post_reset_halt", state, 2'b00);
        checkOutput("post_reset_cyc_cnt", cyc_cnt, expCnt(pulses));
        checkOutput("scoreboard_drained", sb.size(), 0);

        // DIV=1 instance: continuous enable and counter saturation.
        while (cnt2 < 70000 && cyc < 90000) begin
            nextCycle();
        end
        checkOutput("dut2_budget", (cnt2 >= 70000), 1);
        nextCycle();
        nextCycle();
        checkOutput("dut2_state", state2, 2'b01);
        checkOutput("dut2_cpu_en", cpu_en2, 1);
        checkOutput("dut2_flags", {halted2, bp_hit2}, 0);
        checkOutput("dut2_cyc_cnt", cyc_cnt2, expCnt(cnt2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
